// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares one memory request port between the CPU fetch
// side and the data side. One memory transaction at a time; the data side
// wins when both request together; every result is returned with a
// single-cycle addr_ok/data_ok pulse.
module cbus_arbiter #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              iresp_addr_ok,
    output logic              iresp_data_ok,
    output logic [31:0]       iresp_data,

    input  logic              dreq_valid,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [2:0]        dreq_size,
    input  logic [7:0]        dreq_strobe,
    input  logic [63:0]       dreq_data,
    output logic              dresp_addr_ok,
    output logic              dresp_data_ok,
    output logic [63:0]       dresp_data,

    output logic              mreq_valid,
    output logic              mreq_write,
    output logic [ADDR_W-1:0] mreq_addr,
    output logic [2:0]        mreq_size,
    output logic [7:0]        mreq_strobe,
    output logic [63:0]       mreq_data,
    input  logic              mresp_ok,
    input  logic [63:0]       mresp_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IBUSY = 3'd1,
        DBUSY = 3'd2,
        IRESP = 3'd3,
        DRESP = 3'd4
    } state_t;

    state_t            state_q;
    logic              mreq_valid_q;
    logic              mreq_write_q;
    logic [ADDR_W-1:0] mreq_addr_q;
    logic [2:0]        mreq_size_q;
    logic [7:0]        mreq_strobe_q;
    logic [63:0]       mreq_data_q;
    logic              iresp_ok_q;
    logic              dresp_ok_q;
    logic [31:0]       iresp_data_q;
    logic [63:0]       dresp_data_q;

    logic [31:0]       iresp_word_d;
    logic              dreq_write_d;

    // Pick the 32-bit instruction out of the 64-bit memory beat using the
    // latched fetch address, and classify the incoming data request.
    always_comb begin
        iresp_word_d = mreq_addr_q[2] ? mresp_data[63:32] : mresp_data[31:0];
        dreq_write_d = (dreq_strobe != 8'h00);
    end

    // Arbitration FSM; every output is a register so the memory request
    // stays frozen for the whole stall regardless of upstream changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            mreq_valid_q  <= 1'b0;
            mreq_write_q  <= 1'b0;
            mreq_addr_q   <= '0;
            mreq_size_q   <= 3'd0;
            mreq_strobe_q <= 8'h00;
            mreq_data_q   <= 64'h0;
            iresp_ok_q    <= 1'b0;
            dresp_ok_q    <= 1'b0;
            iresp_data_q  <= 32'h0;
            dresp_data_q  <= 64'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dreq_valid) begin
                        // Data side has priority; a simultaneous fetch waits here.
                        state_q       <= DBUSY;
                        mreq_valid_q  <= 1'b1;
                        mreq_write_q  <= dreq_write_d;
                        mreq_addr_q   <= dreq_addr;
                        mreq_size_q   <= dreq_size;
                        mreq_strobe_q <= dreq_strobe;
                        mreq_data_q   <= dreq_data;
                    end else if (ireq_valid) begin
                        state_q       <= IBUSY;
                        mreq_valid_q  <= 1'b1;
                        mreq_write_q  <= 1'b0;
                        mreq_addr_q   <= ireq_addr;
                        mreq_size_q   <= 3'd2;
                        mreq_strobe_q <= 8'h00;
                        mreq_data_q   <= 64'h0;
                    end
                end
                IBUSY: begin
                    if (mresp_ok) begin
                        state_q      <= IRESP;
                        mreq_valid_q <= 1'b0;
                        iresp_ok_q   <= 1'b1;
                        iresp_data_q <= iresp_word_d;
                    end
                end
                DBUSY: begin
                    if (mresp_ok) begin
                        state_q      <= DRESP;
                        mreq_valid_q <= 1'b0;
                        dresp_ok_q   <= 1'b1;
                        dresp_data_q <= mresp_data;
                    end
                end
                IRESP: begin
                    // No grant from here: a still-asserted valid is only
                    // looked at again once back in IDLE.
                    state_q    <= IDLE;
                    iresp_ok_q <= 1'b0;
                end
                DRESP: begin
                    state_q    <= IDLE;
                    dresp_ok_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    mreq_valid_q <= 1'b0;
                    iresp_ok_q   <= 1'b0;
                    dresp_ok_q   <= 1'b0;
                end
            endcase
        end
    end

    assign mreq_valid    = mreq_valid_q;
    assign mreq_write    = mreq_write_q;
    assign mreq_addr     = mreq_addr_q;
    assign mreq_size     = mreq_size_q;
    assign mreq_strobe   = mreq_strobe_q;
    assign mreq_data     = mreq_data_q;
    assign iresp_addr_ok = iresp_ok_q;
    assign iresp_data_ok = iresp_ok_q;
    assign iresp_data    = iresp_data_q;
    assign dresp_addr_ok = dresp_ok_q;
    assign dresp_data_ok = dresp_ok_q;
    assign dresp_data    = dresp_data_q;

endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 64, width of all address ports.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 ireq_valid  in  1  fetch request from cpu ifu, held until iresp_data_ok.
REQ-005 ireq_addr  in  ADDR_W  fetch byte address, 4-byte aligned.
REQ-006 iresp_addr_ok, iresp_data_ok  out  1 each  fetch completion pulses.
REQ-007 iresp_data  out  32  fetched instruction.
REQ-008 dreq_valid  in  1  data request from cpu mem stage, held until dresp_data_ok.
REQ-009 dreq_addr  in  ADDR_W; dreq_size  in  3 (log2 bytes); dreq_strobe  in  8 (0 = read); dreq_data  in  64.
REQ-010 dresp_addr_ok, dresp_data_ok  out  1 each; dresp_data  out  64.
REQ-011 mreq_valid  out  1; mreq_write  out  1; mreq_addr  out  ADDR_W; mreq_size  out  3; mreq_strobe  out  8; mreq_data  out  64.
REQ-012 mresp_ok  in  1  memory completed current mreq; mresp_data  in  64  read data, valid with mresp_ok.

Function
REQ-013 FSM states IDLE, IBUSY, DBUSY, IRESP, DRESP; reset state IDLE.
REQ-014 IDLE, dreq_valid=1 -> DBUSY, latch dreq_addr/size/strobe/data.
REQ-015 IDLE, dreq_valid=0 and ireq_valid=1 -> IBUSY, latch ireq_addr; mreq_size=3'd2, mreq_strobe=0.
REQ-016 Simultaneous ireq_valid and dreq_valid in IDLE: data side wins; fetch waits in IDLE.
REQ-017 IBUSY/DBUSY: mreq_valid=1, mreq_* driven only from latched registers (stable regardless of upstream changes).
REQ-018 mreq_write = (latched strobe != 0); IBUSY always mreq_write=0.
REQ-019 IBUSY/DBUSY with mresp_ok=1: capture mresp_data, go to IRESP/DRESP respectively; else stay.
REQ-020 IRESP: iresp_addr_ok=iresp_data_ok=1 for exactly one cycle; iresp_data = captured[63:32] if latched addr[2]=1, else captured[31:0]; then IDLE.
REQ-021 DRESP: dresp_addr_ok=dresp_data_ok=1 for exactly one cycle; dresp_data = captured 64 bits unmodified (writes return captured value, upstream ignores); then IDLE.
REQ-022 Minimum latency valid-high to data_ok: 2 cycles (grant edge, mresp_ok in first BUSY cycle, RESP cycle).
REQ-023 No new grant in IRESP/DRESP; re-arbitration only in IDLE, so a requester still asserting valid in its RESP cycle is not double-served.
REQ-024 ok/mreq_valid outputs 0 in all states not listed; iresp_data/dresp_data hold last captured value outside RESP.
REQ-025 mresp_ok while IDLE or RESP is ignored.
REQ-026 At most one outstanding memory transaction at any time.

Reset
REQ-027 rst=0 asynchronously forces IDLE; all outputs and latched/captured registers 0.
REQ-028 Reset during IBUSY/DBUSY abandons the transaction: mreq_valid drops immediately; no data_ok pulse afterwards.
REQ-029 First grant occurs no earlier than the first rising edge with rst=1.

Verification
REQ-030 Fetch: ireq addr 0x8000_0004, mresp_ok 1 cycle after mreq_valid with data 0x1111_2222_3333_4444 -> iresp_data 0x1111_2222, single-cycle ok pulse.
REQ-031 Collision: ireq 0x8000_0000 and dreq read 0x8000_1000 same cycle -> mreq_addr 0x8000_1000 first, dresp_data_ok, then fetch mreq 0x8000_0000.
REQ-032 Store: dreq strobe 0x0F, data 0xDEAD_BEEF, size 2 -> mreq_write=1, strobe 0x0F, data 0xDEAD_BEEF stable across 5 stall cycles (mresp_ok=0).
REQ-033 Back-to-back: ireq_valid held through IRESP -> exactly one ok pulse per transaction, next mreq_valid no earlier than one cycle after IRESP.
REQ-034 Reset mid-DBUSY: rst=0 two cycles into a stall -> mreq_valid 0 same cycle, no dresp_data_ok after release.
REQ-035 Stray mresp_ok=1 in IDLE with no requests -> no ok pulses, state stays IDLE.
